// File: rtl/keypad_iface.sv
// 4x4 matrix keypad scanner with column debouncing and a 4-entry key-code FIFO
// read by the CPU through a single memory-mapped status/data word.
module keypad_iface #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  kb_col_i,
    output logic [3:0]  kb_row_o,
    input  logic        IO_read_i,
    output logic [31:0] IO2cpu_o,
    output logic [3:0]  keyboard_val_o,
    output logic        key_pressed_o
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD,
        ST_RELEASE
    } state_e;

    logic [3:0]       col_meta_q, col_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    state_e           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_val_q, key_val_d;
    logic             key_pressed_q, key_pressed_d;

    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       mem_q [4];

    logic       sample, any_low, col_held, push;
    logic [1:0] first_low;
    logic [3:0] push_code;
    logic       fifo_empty, fifo_full, pop, push_ok;

    assign sample    = (div_q == DIV_LAST);
    assign any_low   = (col_sync_q != 4'hF);
    assign col_held  = ~col_sync_q[col_idx_q];
    assign push_code = {row_q, col_idx_q};

    always_comb begin
        casez (col_sync_q)
            4'b???0: first_low = 2'd0;
            4'b??01: first_low = 2'd1;
            4'b?011: first_low = 2'd2;
            default: first_low = 2'd3;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        div_d     = sample ? '0 : div_q + DIV_W'(1);
        state_d   = state_q;
        row_d     = row_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        key_val_d = key_val_q;
        push      = 1'b0;
        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        col_idx_d = first_low;
                        cnt_d     = CNT_W'(1);
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_held) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            push      = 1'b1;
                            key_val_d = push_code;
                            state_d   = ST_HOLD;
                        end
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    if (!any_low) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    if (any_low) begin
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            row_d   = row_q + 2'd1;
                            state_d = ST_SCAN;
                        end
                    end
                end
            endcase
        end
        key_pressed_d = (state_d == ST_HOLD) || (state_d == ST_RELEASE);
    end

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign pop        = IO_read_i && !fifo_empty;
    // A full FIFO still accepts a push when the same edge pops an entry.
    assign push_ok    = push && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end else if (IO_read_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            col_meta_q    <= 4'hF;
            col_sync_q    <= 4'hF;
            div_q         <= '0;
            state_q       <= ST_SCAN;
            row_q         <= 2'd0;
            col_idx_q     <= 2'd0;
            cnt_q         <= '0;
            key_val_q     <= 4'd0;
            key_pressed_q <= 1'b0;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            count_q       <= 3'd0;
            ovf_q         <= 1'b0;
        end else begin
            col_meta_q    <= kb_col_i;
            col_sync_q    <= col_meta_q;
            div_q         <= div_d;
            state_q       <= state_d;
            row_q         <= row_d;
            col_idx_q     <= col_idx_d;
            cnt_q         <= cnt_d;
            key_val_q     <= key_val_d;
            key_pressed_q <= key_pressed_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
        end
    end

    // NOTE: the storage array is not reset; the count gates every read, so stale
    // entries are never visible and the array can map onto plain registers/RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    assign kb_row_o       = ~(4'b0001 << row_q);
    assign keyboard_val_o = key_val_q;
    assign key_pressed_o  = key_pressed_q;
    assign IO2cpu_o       = {~fifo_empty, ovf_q, 23'd0, count_q,
                             fifo_empty ? 4'd0 : mem_q[rd_ptr_q]};

endmodule

// File: tb/tb_keypad_iface.sv
// Directed bench for keypad_iface: a keypad model drives the columns from the
// row strobes, and a queue scoreboard predicts every CPU read word.
module tb_keypad_iface;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  kb_col;
    logic [3:0]  kb_row;
    logic        io_read = 1'b0;
    logic [31:0] io2cpu;
    logic [3:0]  kval;
    logic        kpressed;

    logic        key_down = 1'b0;
    logic [1:0]  key_row = 2'd0;
    logic [1:0]  key_col = 2'd0;
    logic        col_ovr_en = 1'b0;
    logic [3:0]  col_ovr = 4'hF;

    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  exp_q[$];
    logic        exp_ovf = 1'b0;
    logic [3:0]  exp_kval = 4'd0;

    keypad_iface #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .kb_col_i       (kb_col),
        .kb_row_o       (kb_row),
        .IO_read_i      (io_read),
        .IO2cpu_o       (io2cpu),
        .keyboard_val_o (kval),
        .key_pressed_o  (kpressed)
    );

    always #5 clk = ~clk;

    // Pressed key shorts its column to its row: column goes low only while that row is driven.
    always_comb begin
        if (col_ovr_en) kb_col = col_ovr;
        else if (key_down && !kb_row[key_row]) kb_col = ~(4'b0001 << key_col);
        else kb_col = 4'hF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word();
        int n;
        logic [3:0] h;
        n = exp_q.size();
        h = (n != 0) ? exp_q[0] : 4'd0;
        return {(n != 0), exp_ovf, 23'd0, 3'(n), h};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_kval = 4'd0;
    endtask

    task automatic model_push(input logic [3:0] code);
        if (exp_q.size() < 4) exp_q.push_back(code);
        else exp_ovf = 1'b1;
        exp_kval = code;
    endtask

    task automatic do_read(input string tag);
        check(tag, io2cpu, exp_word());
        io_read = 1'b1;
        cyc(1);
        io_read = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_ovf = 1'b0;
    endtask

    task automatic wait_pressed(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (kpressed !== lvl && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, kpressed, lvl);
    endtask

    // Returns at the first cycle of a fresh window driving row r.
    task automatic wait_row_entry(input logic [1:0] r);
        int n = 0;
        logic [3:0] pat;
        pat = ~(4'b0001 << r);
        while (kb_row == pat && n < 40) begin cyc(1); n++; end
        while (kb_row != pat && n < 40) begin cyc(1); n++; end
        check("row_entry", kb_row, pat);
    endtask

    task automatic press_release(input logic [3:0] code);
        key_row  = code[3:2];
        key_col  = code[1:0];
        key_down = 1'b1;
        wait_pressed(1'b1, 200, "press_accept");
        model_push(code);
        check("press_kval", kval, exp_kval);
        key_down = 1'b0;
        wait_pressed(1'b0, 200, "press_release");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;

        // Reset values, then row stepping every SCAN_DIV cycles with wrap.
        do_reset();
        check("rst_row", kb_row, 4'b1110);
        check("rst_word", io2cpu, 32'h0);
        check("rst_kval", kval, 4'd0);
        check("rst_pressed", kpressed, 1'b0);
        cyc(3);  check("row0_hold", kb_row, 4'b1110);
        cyc(1);  check("row1", kb_row, 4'b1101);
        cyc(4);  check("row2", kb_row, 4'b1011);
        cyc(4);  check("row3", kb_row, 4'b0111);
        cyc(4);  check("row_wrap", kb_row, 4'b1110);

        // Row 2 col 1: detect at end of window, push 8 cycles later.
        key_row = 2'd2; key_col = 2'd1; key_down = 1'b1;
        wait_row_entry(2'd2);
        cyc(11); check("push_latency_early", kpressed, 1'b0);
        cyc(1);  check("push_latency", kpressed, 1'b1);
        model_push(4'd9);
        check("push_word", io2cpu, exp_word());
        check("push_kval", kval, exp_kval);
        do_read("read_key9");
        check("after_read", io2cpu, exp_word());
        cyc(100);
        check("hold_no_repush", io2cpu, exp_word());
        check("hold_pressed", kpressed, 1'b1);
        key_down = 1'b0;
        cyc(9);  check("release_early", kpressed, 1'b1);
        wait_pressed(1'b0, 20, "release_done");

        // Bounce on col0: samples alternate low/high, never accepted.
        saw = 1'b0;
        col_ovr_en = 1'b1;
        for (int w = 0; w < 10; w++) begin
            col_ovr = (w % 2 == 0) ? 4'hE : 4'hF;
            for (int c = 0; c < SCAN_DIV; c++) begin
                cyc(1);
                if (kpressed) saw = 1'b1;
            end
        end
        col_ovr = 4'hF;
        cyc(12);
        col_ovr_en = 1'b0;
        check("bounce_never_pressed", saw, 1'b0);
        check("bounce_word", io2cpu, exp_word());
        check("bounce_pressed", kpressed, 1'b0);

        // Five presses, no reads: fifth is dropped and sets overflow.
        do_reset();
        press_release(4'd1);
        press_release(4'd5);
        press_release(4'd10);
        press_release(4'd15);
        press_release(4'd3);
        check("ovf_kval", kval, 4'd3);
        do_read("ovf_read0");
        do_read("ovf_read1");
        do_read("ovf_read2");
        do_read("ovf_read3");
        check("ovf_drained", io2cpu, exp_word());

        // Full FIFO: push and pop on the same edge.
        do_reset();
        press_release(4'd2);
        press_release(4'd7);
        press_release(4'd8);
        press_release(4'd13);
        key_row = 2'd3; key_col = 2'd2; key_down = 1'b1;
        wait_row_entry(2'd3);
        cyc(11);
        check("full_pre", io2cpu, exp_word());
        io_read = 1'b1;
        cyc(1);
        io_read = 1'b0;
        void'(exp_q.pop_front());
        exp_ovf = 1'b0;
        model_push(4'd14);
        check("pushpop_pressed", kpressed, 1'b1);
        check("pushpop_word", io2cpu, exp_word());
        check("pushpop_kval", kval, exp_kval);
        do_read("pushpop_read0");
        do_read("pushpop_read1");
        do_read("pushpop_read2");
        do_read("pushpop_read3");
        check("pushpop_drained", io2cpu, exp_word());
        key_down = 1'b0;
        wait_pressed(1'b0, 40, "pushpop_release");

        // Reset one sample into DEBOUNCE discards the pending key.
        do_reset();
        key_row = 2'd1; key_col = 2'd2; key_down = 1'b1;
        wait_row_entry(2'd1);
        cyc(4);
        key_down = 1'b0;
        do_reset();
        check("mid_rst_row", kb_row, 4'b1110);
        check("mid_rst_word", io2cpu, exp_word());
        check("mid_rst_pressed", kpressed, 1'b0);
        cyc(40);
        check("mid_rst_no_push", io2cpu, exp_word());
        check("mid_rst_kval", kval, exp_kval);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_iface.md
# keypad_iface

Input-side peripheral for the 4x4 matrix keypad on the board I/O path. It scans the keypad rows and debounces column returns. Each accepted keypress becomes a 4-bit key code, queued in a 4-entry FIFO that the CPU reads through a memory-mapped word with a one-cycle read strobe. The last accepted code is also exported as `keyboard_val_o` for the LED/IO output block.

## Interface
- `SCAN_DIV`, 50000: clock cycles per row window (1 ms at 50 MHz); minimum 2.
- `DEBOUNCE_SCANS`, 8: consecutive identical samples required to accept a press or a release; minimum 2.
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `kb_col_i`  in  4  keypad columns, active-low (pulled up); asynchronous to `clk_i`.
- `kb_row_o`  out  4  row drive, active-low one-hot.
- `IO_read_i`  in  1  CPU read strobe; one pulse per word read.
- `IO2cpu_o`  out  32  read word: [31] valid (FIFO non-empty), [30] overflow sticky, [29:7] zero, [6:4] FIFO count (0–4), [3:0] head key code (zero when empty).
- `keyboard_val_o`  out  4  last debounced key code.
- `key_pressed_o`  out  1  high while a debounced key is held.

## Operation
- Columns pass through a 2-flop synchronizer. All samples use the synchronized value.
- A divider counts 0..SCAN_DIV-1 and then wraps. The sample point is the cycle where the divider equals SCAN_DIV-1.
- Key code = {row[1:0], col[1:0]}. If several columns are low, the lowest column index wins.
- Scanner FSM (`cnt` = matching-sample counter):
  - SCAN: at each sample, if no column is low, advance the row (3 wraps to 0). If any column is low, latch row and col, set cnt=1, and go to DEBOUNCE. The row is frozen from this point.
  - DEBOUNCE: at each sample, if the latched column is still low, increment cnt. When cnt reaches DEBOUNCE_SCANS, push the code, update `keyboard_val_o`, and go to HOLD. On mismatch, advance the row and go to SCAN.
  - HOLD: at each sample, if all columns are high, set cnt=1 and go to RELEASE. Otherwise stay.
  - RELEASE: at each sample, if all columns are high, increment cnt. When cnt reaches DEBOUNCE_SCANS, advance the row and go to SCAN. If any column is low, return to HOLD.
- One push per press, regardless of hold length.
- `key_pressed_o` = 1 in HOLD and RELEASE. It is registered.
- FIFO: depth 4, circular, 2-bit pointers plus a 3-bit count.
  - Push on debounce acceptance.
  - Pop on `IO_read_i` when non-empty.
  - Pop when empty: no effect.
  - Push when full with no pop: the new key is dropped, `keyboard_val_o` is still updated, and overflow is set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Overflow clears on the edge of any `IO_read_i`.
- `IO2cpu_o` is combinational from registered FIFO state. The CPU samples it in the cycle it asserts `IO_read_i`, and the pop takes effect on that edge.

## Timing
- Reset (`rst_n_i`=0 at a rising edge) sets: FSM=SCAN, row=0, `kb_row_o`=4'b1110, divider=0, cnt=0, FIFO empty, overflow=0, `IO2cpu_o`=0, `keyboard_val_o`=0, `key_pressed_o`=0.
- Reset mid-operation (any state, including DEBOUNCE) discards the pending key and FIFO contents.
- `kb_row_o` changes on the edge after a row advance and is held for SCAN_DIV cycles.
- Column-to-sample latency is 2 cycles (synchronizer). Column changes in the last 2 cycles of a window are seen in the next window.
- Push latency: the push happens at the sample edge that takes the DEBOUNCE_SCANS-th matching sample. That is (DEBOUNCE_SCANS-1)·SCAN_DIV cycles after the detection sample.
- FIFO push is visible on `IO2cpu_o` the cycle after that edge.
- `keyboard_val_o` and `key_pressed_o` update on the same edge as the push.
- Read: `IO2cpu_o` shows the next entry the cycle after an `IO_read_i` edge. Back-to-back strobes pop consecutive entries.

## Test plan
All directed tests use SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset: hold `rst_n_i`=0 for 2 cycles → `kb_row_o`=4'b1110, `IO2cpu_o`=32'h0, `keyboard_val_o`=0, `key_pressed_o`=0. Release reset → `kb_row_o` steps 1110→1101→1011→0111 every 4 cycles, then wraps.
- Press row 2 col 1 (col1 low while row2 is driven), held → push 8 cycles after detection. `IO2cpu_o`=32'h8000_0019, `keyboard_val_o`=9, `key_pressed_o`=1. Pulse `IO_read_i` → `IO2cpu_o`=0. Hold the key 100 cycles → no second push. Release → `key_pressed_o`=0 after 3 high samples.
- Bounce: toggle col0 at every sample for 10 windows → no push, count 0, `key_pressed_o`=0.
- Press and release codes 1, 5, 10, 15, 3 with no reads → count=4, overflow=1, `keyboard_val_o`=3.
  - First read sees 32'hC000_0041. Subsequent reads return 5, 10, 15 with bit 30=0, then the valid bit clears.
- With the FIFO full, a push coincides with `IO_read_i` → count stays 4, overflow stays 0, and the new code is at the tail.
- Assert reset one sample into DEBOUNCE → no push, FSM=SCAN, `kb_row_o`=4'b1110.
